// File: rtl/smartbike_pkg.sv
// Shared types and constants for the smartbike sensor front-ends.
package smartbike_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      DIVIDE
   } cadence_state_t;

   localparam int CADENCE_DIV_W = 32;
   localparam logic [7:0] RPM_SAT = 8'd255;

   function automatic logic [7:0] sat_rpm(input logic [CADENCE_DIV_W-1:0] q);
      return (q > CADENCE_DIV_W'(RPM_SAT)) ? RPM_SAT : q[7:0];
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses 32 cycles after start.
// The first bit is resolved on the start edge itself, so start may not be held off by busy.
module seq_divider
   import smartbike_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [CADENCE_DIV_W-1:0] dividend,
   input  logic [CADENCE_DIV_W-1:0] divisor,
   output logic                     busy,
   output logic                     done,
   output logic [CADENCE_DIV_W-1:0] quotient
);

   localparam int W  = CADENCE_DIV_W;
   localparam int CW = $clog2(W);

   logic [W-1:0]  rem;
   logic [W-1:0]  num;
   logic [W-1:0]  den;
   logic [CW-1:0] bit_cnt;

   logic [W-1:0]  rem_src;
   logic [W-1:0]  num_src;
   logic [W-1:0]  den_src;
   logic [W-1:0]  q_src;
   logic [W:0]    shifted;
   logic          ge;
   logic [W-1:0]  rem_nxt;

   always_comb begin
      rem_src = start ? '0 : rem;
      num_src = start ? dividend : num;
      den_src = start ? divisor : den;
      q_src   = start ? '0 : quotient;
      shifted = {rem_src, num_src[W-1]};
      ge      = shifted >= {1'b0, den_src};
      // the partial remainder always stays below the divisor, so W bits hold it
      rem_nxt = ge ? W'(shifted - {1'b0, den_src}) : shifted[W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rem      <= '0;
         num      <= '0;
         den      <= '0;
         quotient <= '0;
         bit_cnt  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start || busy) begin
            rem      <= rem_nxt;
            num      <= {num_src[W-2:0], 1'b0};
            den      <= den_src;
            quotient <= {q_src[W-2:0], ge};
         end
         if (start) begin
            busy    <= 1'b1;
            bit_cnt <= CW'(1);
         end else if (busy) begin
            if (bit_cnt == CW'(W-1)) begin
               busy    <= 1'b0;
               done    <= 1'b1;
               bit_cnt <= '0;
            end else begin
               bit_cnt <= bit_cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/cadence_monitor.sv
// Pedal cadence: sync + debounce + edge period + divide -> RPM; rpm_valid 34 cycles after evt (35 with CADENCE_FILTER_EN).
// No backpressure; CADENCE_FILTER_EN adds a 4-tap moving average on cadence_rpm.
module cadence_monitor
   import smartbike_pkg::*;
#(
   parameter int unsigned CLK_HZ          = 50_000_000,
   parameter int unsigned PULSES_PER_REV  = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 50_000,
   parameter int unsigned TIMEOUT_CYCLES  = 100_000_000
)(
   input  logic        c50m,
   input  logic        reset,
   input  logic        cadence,
   output logic [7:0]  cadence_rpm,
   output logic        rpm_valid,
   output logic        pedaling,
   output logic [31:0] period_cycles
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CADENCE_DIV_W-1:0] NUM =
      CADENCE_DIV_W'(64'(60) * 64'(CLK_HZ) / 64'(PULSES_PER_REV));

   if (DEBOUNCE_CYCLES < 64) begin : g_debounce_check
      $error("DEBOUNCE_CYCLES must be at least 64");
   end

   logic          sync1;
   logic          sync2;
   logic          deb;
   logic          deb_d;
   logic [DW-1:0] deb_cnt;
   logic          evt;
   logic [31:0]   per_cnt;

   cadence_state_t state;
   cadence_state_t next;
   logic           latch_period;
   logic           take_result;
   logic           timeout_hit;
   logic           start_div;

   logic                     div_busy;
   logic                     div_done;
   logic [CADENCE_DIV_W-1:0] quotient;
   logic [7:0]               q_sat;
   logic                     result_vld;
   logic [7:0]               result_rpm;

   assign evt = deb & ~deb_d;

   always_ff @(posedge c50m) begin
      if (reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         deb     <= 1'b0;
         deb_d   <= 1'b0;
         deb_cnt <= '0;
         per_cnt <= '0;
      end else begin
         sync1 <= cadence;
         sync2 <= sync1;
         deb_d <= deb;
         if (sync2 == deb) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            deb     <= sync2;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + DW'(1);
         end
         if (evt) begin
            per_cnt <= 32'd1;
         end else if (per_cnt < TIMEOUT_CYCLES) begin
            per_cnt <= per_cnt + 32'd1;
         end
      end
   end

   always_ff @(posedge c50m) begin
      if (reset) state <= IDLE;
      else       state <= next;
   end

   always_comb begin
      next         = state;
      latch_period = 1'b0;
      take_result  = 1'b0;
      timeout_hit  = 1'b0;
      case (state)
         IDLE: begin
            if (evt) next = MEASURE;
         end
         MEASURE: begin
            if (evt) begin
               latch_period = 1'b1;
               next         = DIVIDE;
            end else if (per_cnt == TIMEOUT_CYCLES) begin
               timeout_hit = 1'b1;
               next        = IDLE;
            end
         end
         DIVIDE: begin
            if (div_done) begin
               take_result = 1'b1;
               next        = MEASURE;
            end
         end
         default: next = IDLE;
      endcase
   end

   seq_divider u_div (
      .clk      (c50m),
      .reset    (reset),
      .start    (start_div),
      .dividend (NUM),
      .divisor  (period_cycles),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (quotient)
   );

   assign q_sat = (period_cycles == '0) ? RPM_SAT : sat_rpm(quotient);

`ifdef CADENCE_FILTER_EN
   logic [7:0] taps [4];
   logic       taps_empty;
   logic       filt_pend;
   logic [9:0] tap_sum;

   always_comb begin
      tap_sum = 10'(taps[0]) + 10'(taps[1]) + 10'(taps[2]) + 10'(taps[3]);
   end

   always_ff @(posedge c50m) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) taps[i] <= '0;
         taps_empty <= 1'b1;
         filt_pend  <= 1'b0;
      end else begin
         filt_pend <= take_result;
         if (timeout_hit) begin
            for (int i = 0; i < 4; i++) taps[i] <= '0;
            taps_empty <= 1'b1;
         end else if (take_result) begin
            // first result after IDLE fills the window so the mean starts on-value
            if (taps_empty) begin
               for (int i = 0; i < 4; i++) taps[i] <= q_sat;
            end else begin
               taps[0] <= q_sat;
               taps[1] <= taps[0];
               taps[2] <= taps[1];
               taps[3] <= taps[2];
            end
            taps_empty <= 1'b0;
         end
      end
   end

   assign result_vld = filt_pend;
   assign result_rpm = 8'(tap_sum >> 2);
`else
   assign result_vld = take_result;
   assign result_rpm = q_sat;
`endif

   always_ff @(posedge c50m) begin
      if (reset) begin
         start_div     <= 1'b0;
         cadence_rpm   <= '0;
         rpm_valid     <= 1'b0;
         pedaling      <= 1'b0;
         period_cycles <= '0;
      end else begin
         start_div <= latch_period;
         rpm_valid <= 1'b0;
         if (latch_period) period_cycles <= per_cnt;
         if (timeout_hit) begin
            cadence_rpm <= '0;
            pedaling    <= 1'b0;
            rpm_valid   <= 1'b1;
         end else if (result_vld) begin
            cadence_rpm <= result_rpm;
            pedaling    <= 1'b1;
            rpm_valid   <= 1'b1;
         end
      end
   end

   // debounce length guarantees the divider finishes before the next edge
   a_no_evt_in_divide: assert property (@(posedge c50m) disable iff (reset)
      !(state == DIVIDE && evt) && !(start_div && div_busy));

endmodule

// File: tb/tb_cadence_monitor.sv
// Directed + randomized bench for cadence_monitor; clock scaled down 1000x so
// 100 RPM is a 3750-cycle period and the timeout is 10_000 cycles.
module tb_cadence_monitor;

   localparam int unsigned CLK_HZ  = 50_000;
   localparam int unsigned PPR     = 8;
   localparam int unsigned DEB     = 64;
   localparam int unsigned TMO     = 10_000;
   localparam int          NUM     = 60 * CLK_HZ / PPR;
`ifdef CADENCE_FILTER_EN
   localparam int          LAT     = 2 + DEB + 35;
`else
   localparam int          LAT     = 2 + DEB + 34;
`endif
   localparam int          HIGH_LEN = 150;

   logic        c50m = 1'b0;
   logic        reset = 1'b1;
   logic        cadence = 1'b0;
   logic [7:0]  cadence_rpm;
   logic        rpm_valid;
   logic        pedaling;
   logic [31:0] period_cycles;

   cadence_monitor #(
      .CLK_HZ          (CLK_HZ),
      .PULSES_PER_REV  (PPR),
      .DEBOUNCE_CYCLES (DEB),
      .TIMEOUT_CYCLES  (TMO)
   ) dut (
      .c50m          (c50m),
      .reset         (reset),
      .cadence       (cadence),
      .cadence_rpm   (cadence_rpm),
      .rpm_valid     (rpm_valid),
      .pedaling      (pedaling),
      .period_cycles (period_cycles)
   );

   always #5 c50m = ~c50m;

   int cyc = 0;
   always @(posedge c50m) cyc <= cyc + 1;

   int ntests = 0;
   int nfail  = 0;
   int nvalid, v_cyc, v_rpm, v_ped, v_period;
   int last_edge;
   int model_active, model_first, model_last;
   int taps [4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge c50m);
      if (rpm_valid === 1'b1) begin
         nvalid++;
         v_cyc    = cyc;
         v_rpm    = int'(cadence_rpm);
         v_ped    = int'(pedaling);
         v_period = int'(period_cycles);
      end
   endtask

   function automatic int quot_sat(input int period);
      int q;
      q = (period == 0) ? 255 : NUM / period;
      return (q > 255) ? 255 : q;
   endfunction

   task automatic model_result(input int period, output int rpm);
      int q;
      q = quot_sat(period);
`ifdef CADENCE_FILTER_EN
      if (model_first != 0) begin
         for (int i = 0; i < 4; i++) taps[i] = q;
         model_first = 0;
      end else begin
         for (int i = 3; i > 0; i--) taps[i] = taps[i-1];
         taps[0] = q;
      end
      rpm = (taps[0] + taps[1] + taps[2] + taps[3]) / 4;
`else
      rpm = q;
`endif
      model_last = rpm;
   endtask

   task automatic model_idle();
      model_active = 0;
      model_first  = 1;
      for (int i = 0; i < 4; i++) taps[i] = 0;
   endtask

   task automatic do_edge(input int gap, input string tag);
      int c, exp_rpm;
      while (cyc < last_edge + gap) tick();
      cadence = 1'b1;
      c = cyc;
      nvalid = 0;
      repeat (HIGH_LEN) tick();
      cadence = 1'b0;
      if (model_active != 0) begin
         model_result(c - last_edge, exp_rpm);
         check({tag, "_nvalid"}, nvalid, 1);
         check({tag, "_when"}, v_cyc, c + LAT);
         check({tag, "_rpm"}, v_rpm, exp_rpm);
         check({tag, "_ped"}, v_ped, 1);
         check({tag, "_period"}, v_period, c - last_edge);
      end else begin
         check({tag, "_no_valid"}, nvalid, 0);
      end
      model_active = 1;
      last_edge = c;
   endtask

   initial begin
      int e_last, c;
      model_idle();
      model_last = 0;
      nvalid = 0;

      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("rst_rpm", cadence_rpm, 0);
      check("rst_valid", rpm_valid, 0);
      check("rst_ped", pedaling, 0);
      check("rst_period", period_cycles, 0);

      // short glitch must be rejected by the debouncer
      cadence = 1'b1;
      repeat (30) tick();
      cadence = 1'b0;
      nvalid = 0;
      repeat (200) tick();
      check("glitch_nvalid", nvalid, 0);
      check("glitch_ped", pedaling, 0);
      check("glitch_rpm", cadence_rpm, 0);

      last_edge = cyc;
      do_edge(0, "a0");
      do_edge(3750, "a1");
      do_edge(3750, "a2");
      do_edge(6250, "a3");
      do_edge(6250, "a4");

      // input held low: timeout TMO cycles after the last evt
      e_last = last_edge + 2 + DEB;
      nvalid = 0;
      while (cyc < e_last + TMO - 5) tick();
      check("tmo_not_early_ped", pedaling, 1);
      check("tmo_not_early_valid", nvalid, 0);
      while (cyc < e_last + TMO + 5) tick();
      check("tmo_nvalid", nvalid, 1);
      check("tmo_rpm", v_rpm, 0);
      check("tmo_ped", v_ped, 0);
      check("tmo_when", (v_cyc >= e_last + TMO) && (v_cyc <= e_last + TMO + 2), 1);
      check("tmo_ped_after", pedaling, 0);
      model_idle();

      last_edge = cyc;
      do_edge(1, "single");
      do_edge(1000, "fast0");
      do_edge(1000, "fast1");
      do_edge(1470, "sat_edge");
      do_edge(1472, "below_sat");

      // reset 10 cycles after the divider starts
      while (cyc < last_edge + 3750) tick();
      cadence = 1'b1;
      c = cyc;
      while (cyc < c + DEB + 13) tick();
      check("pre_rst_rpm", cadence_rpm, model_last);
      check("pre_rst_ped", pedaling, 1);
      reset = 1'b1;
      cadence = 1'b0;
      nvalid = 0;
      tick();
      check("midrst_rpm", cadence_rpm, 0);
      check("midrst_valid", rpm_valid, 0);
      check("midrst_ped", pedaling, 0);
      check("midrst_period", period_cycles, 0);
      reset = 1'b0;
      repeat (200) tick();
      check("midrst_no_valid", nvalid, 0);
      model_idle();

      last_edge = cyc;
      do_edge(1, "post_rst0");
      do_edge(3750, "post_rst1");

      for (int i = 0; i < 3; i++) begin
         do_edge(int'($urandom_range(700, 4000)), $sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
